// File: rtl/sb_clk_ce_manager.sv
// Fabric clock conditioning: qualifies the CCC PLL lock (2-flop synchroniser
// plus a consecutive-high filter), sequences the fabric reset release from the
// qualified lock, and produces NUM_CH programmable clock-enable strobes on GL0.

// One clock-enable channel: shadow divide, period counter and a pending load
// that is held back until the period boundary so no period is ever cut short
// or stretched.
module sb_clk_ce_chan #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             ce
);

  logic [DIV_W-1:0] sh_q, sh_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             wrap;

  assign wrap = (cnt_q == sh_q);

  // Strobe is a pure decode of registered state plus the enable qualifier.
  assign ce = active & wrap;

  // Counter and shadow/pending update.
  always_comb begin
    cnt_d      = '0;
    sh_d       = sh_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (!active) begin
      // Idle channel: a load (or a still-pending one) lands immediately.
      if (load) begin
        sh_d       = load_val;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        sh_d       = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (wrap) begin
      // Period boundary: a coincident load beats any older pending value.
      cnt_d = '0;
      if (load) begin
        sh_d = load_val;
      end else if (pend_vld_q) begin
        sh_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (load) begin
        // Later loads overwrite an untransferred one.
        pend_d     = load_val;
        pend_vld_d = 1'b1;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

endmodule

module sb_clk_ce_manager #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 8,
  parameter int LOCK_FILT = 16,
  parameter int RST_DLY   = 8
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    PLL_LOCK,
  input  logic [NUM_CH*DIV_W-1:0] DIV_VAL,
  input  logic [NUM_CH-1:0]       DIV_LOAD,
  input  logic [NUM_CH-1:0]       CH_EN,
  input  logic                    LOCK_LOST_CLR,
  output logic [NUM_CH-1:0]       CE,
  output logic                    LOCK_OK,
  output logic                    FAB_RESET_N,
  output logic                    LOCK_LOST,
  output logic [1:0]              STATE
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int HW = $clog2(RST_DLY + 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  logic [1:0]    sync_q, sync_d;
  logic          lock_s;
  logic [FW-1:0] filt_q, filt_d;
  logic          lock_ok_q, lock_ok_d;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          fab_q, fab_d;
  logic          lost_q, lost_d;
  logic          run_w;

  // Two-flop synchroniser for the raw, asynchronous PLL lock.
  always_comb begin
    sync_d = {sync_q[0], PLL_LOCK};
  end

  assign lock_s = sync_q[1];

  // Stability filter: count consecutive synced-high cycles, saturate, and
  // drop immediately on any low cycle (no hysteresis on loss).
  always_comb begin
    filt_d = filt_q;
    if (!lock_s) begin
      filt_d = '0;
    end else if (filt_q != FW'(LOCK_FILT)) begin
      filt_d = filt_q + 1'b1;
    end
    lock_ok_d = lock_s && (filt_q == FW'(LOCK_FILT));
  end

  // Reset sequencer next-state. Entry into RST_HOLD follows the registered
  // LOCK_OK; loss uses the next LOCK_OK value so the fabric reset, the CE
  // shutdown and LOCK_LOST land on the same edge that clears LOCK_OK.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fab_d   = fab_q;
    lost_d  = lost_q & ~LOCK_LOST_CLR;
    case (state_q)
      S_WAIT: begin
        fab_d = 1'b0;
        if (lock_ok_q) begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
      end
      S_HOLD: begin
        fab_d = 1'b0;
        if (!lock_ok_d) begin
          state_d = S_WAIT;
        end else if (hold_q == HW'(RST_DLY - 1)) begin
          state_d = S_RUN;
          fab_d   = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        fab_d = 1'b1;
        if (!lock_ok_d) begin
          state_d = S_WAIT;
          fab_d   = 1'b0;
          lost_d  = 1'b1;   // set beats a coincident clear
        end
      end
      default: begin
        state_d = S_WAIT;
        fab_d   = 1'b0;
      end
    endcase
  end

  // Lock qualification and reset sequencer registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q    <= '0;
      filt_q    <= '0;
      lock_ok_q <= 1'b0;
      state_q   <= S_WAIT;
      hold_q    <= '0;
      fab_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      filt_q    <= filt_d;
      lock_ok_q <= lock_ok_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      fab_q     <= fab_d;
      lost_q    <= lost_d;
    end
  end

  assign run_w       = (state_q == S_RUN);
  assign LOCK_OK     = lock_ok_q;
  assign FAB_RESET_N = fab_q;
  assign LOCK_LOST   = lost_q;
  assign STATE       = state_q;

  // Channels share RUN state, so channels enabled beforehand start in phase.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sb_clk_ce_chan #(.DIV_W(DIV_W)) u_ch (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .active   (run_w & CH_EN[i]),
      .load     (DIV_LOAD[i]),
      .load_val (DIV_VAL[i*DIV_W +: DIV_W]),
      .ce       (CE[i])
    );
  end

endmodule

// File: doc/sb_clk_ce_manager.md
Name: sb_clk_ce_manager

Overview:
- Parametrised successor to the fabric clock conditioning wrapper. It takes the PLL lock from the CCC and qualifies it with a synchroniser and a stability filter.
- It sequences the fabric reset release from the qualified lock.
- It generates NUM_CH independent, runtime-programmable clock-enable strobes on the single global clock.
- Sits between the CCC instance (GL0/LOCK) and fabric logic, replacing per-frequency CCC outputs with CE-qualified domains.

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..8).
- DIV_W, 8, width of each channel divide value.
- LOCK_FILT, 16, consecutive synchronised-lock-high cycles required before lock is qualified (2..65535).
- RST_DLY, 8, cycles FAB_RESET_N is held low after lock qualification (1..255).

Ports:
- CLK  in  1  global fabric clock (GL0 domain); all logic rising-edge.
- RESET_N  in  1  asynchronous active-low reset.
- PLL_LOCK  in  1  raw CCC LOCK, asynchronous to CLK.
- DIV_VAL  in  NUM_CH*DIV_W  per-channel divide value; channel i occupies bits [i*DIV_W +: DIV_W].
- DIV_LOAD  in  NUM_CH  per-channel single-cycle load strobe for DIV_VAL.
- CH_EN  in  NUM_CH  per-channel enable.
- LOCK_LOST_CLR  in  1  single-cycle clear for LOCK_LOST.
- CE  out  NUM_CH  per-channel clock-enable strobe.
- LOCK_OK  out  1  filtered lock status.
- FAB_RESET_N  out  1  fabric reset, active-low, synchronous release.
- LOCK_LOST  out  1  sticky flag: lock dropped while in RUN.
- STATE  out  2  FSM state for debug (0 WAIT_LOCK, 1 RST_HOLD, 2 RUN).

Behaviour:
- Reset values (RESET_N low, asynchronous):
  - CE=0, LOCK_OK=0, FAB_RESET_N=0, LOCK_LOST=0, STATE=WAIT_LOCK.
  - Synchroniser flops, filter counter, hold counter and channel counters = 0.
  - Shadow divide registers = 0.
- Synchroniser: PLL_LOCK passes through 2 flops to give lock_s. Latency from PLL_LOCK to lock_s is 2 cycles.
- Filter:
  - Counter increments while lock_s=1, saturating at LOCK_FILT.
  - LOCK_OK is registered high in the cycle after the counter reaches LOCK_FILT.
  - lock_s=0 clears the counter and LOCK_OK on the next edge; there is no hysteresis on loss.
- FSM:
  - WAIT_LOCK: FAB_RESET_N=0. Goes to RST_HOLD when LOCK_OK=1; the hold counter loads 0.
  - RST_HOLD: FAB_RESET_N=0; the hold counter increments. Goes to RUN when the counter reaches RST_DLY-1. Goes to WAIT_LOCK if LOCK_OK=0.
  - RUN: FAB_RESET_N=1, registered and deasserted on the RUN entry edge. Goes to WAIT_LOCK on LOCK_OK=0; in the same edge FAB_RESET_N=0, all CE=0 and LOCK_LOST=1.
  - Unused state encoding 3 goes to WAIT_LOCK.
- LOCK_LOST:
  - Sticky; cleared by LOCK_LOST_CLR.
  - If a set condition and LOCK_LOST_CLR occur in the same cycle, set wins.
- Channels, each independent, with shadow register sh[i] and counter cnt[i] (DIV_W bits):
  - Active when STATE=RUN and CH_EN[i]=1. Otherwise cnt[i] is held at 0.
  - When active: cnt increments each cycle and wraps to 0 after equalling sh[i].
  - CE[i] = active & (cnt[i]==sh[i]). This is a decode of registered state and is glitch-free.
  - CE period is sh[i]+1 cycles, high for 1 cycle. sh[i]=0 gives CE[i] constantly high while active.
  - First CE after activation is at cycle sh[i], counting the first active cycle as 0.
  - All channels enabled before RUN entry start in phase.
- DIV_LOAD[i]:
  - If channel inactive: sh[i] takes DIV_VAL slice on the next edge.
  - If active: the value is held pending and transferred to sh[i] on the edge where cnt wraps (cnt==sh[i]). No truncated or extended period is produced.
  - A second load before transfer overwrites the pending value.
  - A load coincident with the wrap transfers the new value on that edge.
- CH_EN deassert mid-period: CE[i]=0 from the next cycle and cnt clears. Re-enable restarts phase at 0.
- Reset mid-operation: all outputs return to their reset values immediately; the pending load is discarded.

Test Plan:
- Reset then PLL_LOCK=1 at cycle 0, LOCK_FILT=16, RST_DLY=8 -> LOCK_OK high at cycle 19, FAB_RESET_N high at cycle 28, STATE=2.
- Glitch: PLL_LOCK high for 10 cycles, low for 1, then high -> LOCK_OK stays 0 until 16 consecutive synced-high cycles; FAB_RESET_N stays 0 throughout.
- In RUN, DIV_VAL ch0=3, ch1=0, ch2=9, all loaded and enabled before RUN:
  - CE0 high every 4th cycle, starting cycle 3 of RUN.
  - CE1 constantly high.
  - CE2 high every 10th cycle.
- Ch0 running at div 3, load 1 mid-period (cnt=1) -> the current 4-cycle period completes, then CE0 has period 2; no short pulse gap.
- Drop PLL_LOCK in RUN -> 3 cycles later FAB_RESET_N=0, CE=0, LOCK_LOST=1, STATE=0. LOCK_LOST_CLR pulse clears it. Re-lock repeats the full sequence.
- Assert RESET_N low during RST_HOLD and during RUN with CH_EN=1111 -> all outputs are at reset values in the same cycle, asynchronously; after release, the sequence restarts from WAIT_LOCK.
